// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO register offsets (A_dm[15:0] within the MMIO window)
//   - run-control state encoding
//   - STATUS register bit positions
package dmem_pkg;

    localparam logic [15:0] OFF_STATUS = 16'h0000;
    localparam logic [15:0] OFF_RESULT = 16'h0004;
    localparam logic [15:0] OFF_CYCLES = 16'h0008;
    localparam logic [15:0] OFF_STORES = 16'h000C;

    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_PASS_BIT = 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DONE_PASS = 2'd1,
        DONE_FAIL = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-addressed storage array.
//   Asynchronous read, synchronous write, contents not reset.
//   Ports:
//     clk   - write clock
//     we    - write enable, sampled at posedge clk
//     addr  - word index
//     wdata - write data
//     rdata - read data, combinational from addr (old data on same-cycle write)
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's data-memory port.
//   Holds a word RAM (dmem_ram), an MMIO window selected by A_dm[31:16]==MMIO_HI,
//   and a run-control FSM that latches the first RESULT write as done/pass.
//   Optional performance counters (CYCLES, STORES) are built when the macro
//   DMEM_PERF_EN is defined; otherwise their offsets read 0.
//   Ports:
//     clk           - single clock, rising edge
//     rst           - asynchronous active-low reset
//     A_dm          - byte address (bits [1:0] ignored)
//     write_data_dm - store data
//     we_dm         - store strobe
//     read_data_dm  - combinational load data
//     done          - a result has been written since reset
//     pass          - the latched result equalled PASS_CODE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] PASS_CODE   = 32'h7,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A_dm,
    input  logic [31:0] write_data_dm,
    input  logic        we_dm,
    output logic [31:0] read_data_dm,
    output logic        done,
    output logic        pass
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t state;

    logic          mmio_sel;
    logic [15:0]   mmio_off;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          result_wr;
    logic [31:0]   ram_rdata;

    assign mmio_sel  = (A_dm[31:16] == MMIO_HI);
    assign mmio_off  = A_dm[15:0];
    // Upper address bits are dropped, so RAM addresses wrap modulo the depth.
    assign ram_idx   = A_dm[AW+1:2];
    assign ram_we    = we_dm && !mmio_sel;
    assign result_wr = we_dm && mmio_sel && (mmio_off == OFF_RESULT);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (write_data_dm),
        .rdata (ram_rdata)
    );

    // Run-control: the first RESULT write decides the outcome; DONE_* are terminal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else if (state == RUN && result_wr) begin
            state <= (write_data_dm == PASS_CODE) ? DONE_PASS : DONE_FAIL;
        end
    end

    assign done = (state != RUN);
    assign pass = (state == DONE_PASS);

`ifdef DMEM_PERF_EN
    logic [31:0] cycles;
    logic [15:0] stores;

    // The edge that leaves RUN is excluded, so CYCLES counts edges spent in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles <= '0;
        end else if (state == RUN && !result_wr) begin
            cycles <= cycles + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stores <= '0;
        end else if (ram_we && stores != 16'hFFFF) begin
            stores <= stores + 16'd1;
        end
    end
`endif

    always_comb begin
        read_data_dm = '0;
        if (!mmio_sel) begin
            read_data_dm = ram_rdata;
        end else begin
            case (mmio_off)
                OFF_STATUS: begin
                    read_data_dm[STATUS_DONE_BIT] = done;
                    read_data_dm[STATUS_PASS_BIT] = pass;
                end
`ifdef DMEM_PERF_EN
                OFF_CYCLES: read_data_dm = cycles;
                OFF_STORES: read_data_dm = {16'b0, stores};
`endif
                default:    read_data_dm = '0;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MCU: the slave end of the core's data-memory write/read port (`A_dm`, `write_data_dm`, `we_dm`). It holds a word-addressed RAM with asynchronous read and synchronous write. It also decodes a small MMIO window containing a test-result register and performance counters. A run-control FSM latches the first result write as done/pass, so benches and top-level logic observe completion on dedicated outputs instead of snooping the bus.

## Interface
- `DEPTH_WORDS`, 64: RAM depth in 32-bit words; power of two.
- `PASS_CODE`, 32'h7: value written to RESULT that signals pass.
- `MMIO_HI`, 16'hFFFF: `A_dm[31:16]` value that selects the MMIO window.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `A_dm` in 32: byte address from the core; `[1:0]` ignored (word aligned).
- `write_data_dm` in 32: store data.
- `we_dm` in 1: store strobe, sampled at `posedge clk`.
- `read_data_dm` out 32: load data, combinational from `A_dm`.
- `done` out 1: a result has been written since reset.
- `pass` out 1: the latched result equalled `PASS_CODE`.

## Operation
- Decode:
  - `A_dm[31:16]==MMIO_HI` selects MMIO.
  - Otherwise RAM, index = `A_dm[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses wrap modulo the depth.
- RAM:
  - A write with `we_dm=1` updates the word at the edge.
  - A read returns the current array content; same-cycle read-after-write returns old data.
  - Contents are not reset.
- MMIO offsets (`A_dm[15:0]`):
  - 0x0000 STATUS, read-only: `{30'b0, pass, done}`.
  - 0x0004 RESULT, write-only; reads return 0.
  - 0x0008 CYCLES, read-only.
  - 0x000C STORES, read-only: `{16'b0, cnt}`.
  - Other offsets read 0. Writes to read-only or unmapped offsets are ignored.
  - MMIO writes never touch the RAM.
- FSM states: RUN (reset state), DONE_PASS, DONE_FAIL.
  - RUN + RESULT write of `PASS_CODE` → DONE_PASS.
  - RUN + RESULT write of any other value → DONE_FAIL.
  - DONE_* are terminal until reset. Further RESULT writes are ignored, so the first result sticks.
  - RAM stores are still accepted in DONE_*.
- `done` = state≠RUN. `pass` = state==DONE_PASS. Both come straight from the state register.

## Timing
- Reset values:
  - state RUN, `done`=0, `pass`=0, CYCLES=0, STORES=0.
  - `read_data_dm` follows `A_dm` combinationally, so it is valid during reset.
- Load latency is 0 cycles (combinational). Store latency is 1 edge.
- A RESULT write at edge N makes `done`/`pass` high after edge N. STATUS reads 0x3 (pass) or 0x1 (fail) from then on.
- CYCLES:
  - Increments on every edge while in RUN, wrapping at 2^32.
  - The edge that leaves RUN does not increment it. Value is frozen in DONE_*.
- STORES:
  - 16-bit counter, incremented on each RAM store (not MMIO) in any state.
  - Saturates at 0xFFFF.
- Only one access occurs per cycle, so there are no simultaneous-access cases.
- Reset asserted mid-run clears the FSM and counters immediately (asynchronously); RAM keeps its data.
- Reset deassertion is synchronized by the caller; the block assumes it is release-safe.

## Configuration
- `DMEM_PERF_EN` defined: CYCLES and STORES counters are built as specified.
- `DMEM_PERF_EN` undefined: counters are not instantiated, and offsets 0x0008/0x000C read 0.
- The RAM, FSM and STATUS/RESULT registers are unaffected either way.

## Structure
- `dmem_pkg` holds:
  - MMIO offset constants `OFF_STATUS`, `OFF_RESULT`, `OFF_CYCLES`, `OFF_STORES`.
  - The state typedef `dmem_state_t` {RUN, DONE_PASS, DONE_FAIL}.
  - A `STATUS_DONE_BIT`/`STATUS_PASS_BIT` index pair.
- Sub-module `dmem_ram`: parameterized storage array (async read, sync write, no reset).
- The top level contains the decode, MMIO mux, FSM and counters.

## Test plan
- Reset low 3 cycles, then high → `done`=0, `pass`=0, STATUS=0.
  - Store 0x12345678 @0x10, load 0x10 → 0x12345678.
- Store 0xCAFEF00D @(DEPTH_WORDS*4+0x10), load 0x10 → 0xCAFEF00D (wrap).
  - Store 0x55 @0xFFFF0000 (read-only) → STATUS still 0.
- Store 7 @0xFFFF0004 → `done`=1, `pass`=1 next cycle, STATUS=0x3.
  - Then store 5 @0xFFFF0004 → unchanged.
  - Then store 0xAA @0x20 → load 0x20 = 0xAA.
- Fresh reset, store 5 @0xFFFF0004 → `done`=1, `pass`=0, STATUS=0x1.
- `DMEM_PERF_EN` defined:
  - Sequence: release reset, idle 10 edges, 3 RAM stores on consecutive edges, then RESULT=7.
  - Expected: CYCLES=13 and stays 13, STORES=3.
  - Undefined: both read 0.
- Store 0x1 @0x08, result 7 → `done`=1.
  - Assert reset mid-cycle → `done`/`pass` drop immediately.
  - After release, load 0x08 → 0x1.
